// File: rtl/iab_serializer_fifo.sv
// IAB serializer: buffers wide A-side frames in a FIFO and emits each one as
// IN_W/OUT_W slices on the IAB bus under a reqIAB/gntIAB arbitration.
module iab_serializer_fifo #(
  parameter int IN_W      = 64,
  parameter int OUT_W     = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b0,
  parameter bit BURST     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         readyA,
  input  logic [IN_W-1:0]              dataA,
  output logic                         acceptedA,
  output logic                         reqIAB,
  input  logic                         gntIAB,
  input  logic                         acceptedI,
  output logic [OUT_W-1:0]             dataOut,
  output logic                         validOut,
  output logic                         lastOut,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int N  = IN_W / OUT_W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  if (IN_W % OUT_W != 0) begin : gBadWidth
    $error("iab_serializer_fifo: IN_W must be a multiple of OUT_W");
  end
  if (DEPTH < 1) begin : gBadDepth
    $error("iab_serializer_fifo: DEPTH must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, SEND} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            accA_q, accA_d;
  logic [IN_W-1:0] mem_q [DEPTH];

  logic            push;
  logic            pop;
  logic [IW-1:0]   sliceSel;
  int              sliceBase;
  logic [IN_W-1:0] head;

  function automatic logic [PW-1:0] wrapInc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Space is judged on the registered level, so a pop frees room only next cycle.
  always_comb begin
    push = readyA && !accA_q && (level_q < LW'(DEPTH));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != '0) state_d = REQ;
      end
      REQ: begin
        if (gntIAB) state_d = SEND;
      end
      SEND: begin
        if (!gntIAB) begin
          state_d = REQ;
        end else if (acceptedI) begin
          if (idx_q == IW'(N - 1)) begin
            pop   = 1'b1;
            idx_d = '0;
            if (level_q > LW'(1)) state_d = BURST ? SEND : REQ;
            else                  state_d = IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accA_d  = accA_q;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (push)                accA_d = 1'b1;
    else if (!readyA)        accA_d = 1'b0;
    if (push)                wrPtr_d = wrapInc(wrPtr_q);
    if (pop)                 rdPtr_d = wrapInc(rdPtr_q);
    if (push && !pop)        level_d = level_q + LW'(1);
    else if (!push && pop)   level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
      accA_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
      accA_q  <= accA_d;
    end
  end

  // Frame storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= dataA;
  end

  always_comb begin
    head      = mem_q[rdPtr_q];
    sliceSel  = MSB_FIRST ? (IW'(N - 1) - idx_q) : idx_q;
    sliceBase = 32'(sliceSel) * OUT_W;
    validOut  = (state_q == SEND);
    reqIAB    = (state_q != IDLE);
    lastOut   = validOut && (idx_q == IW'(N - 1));
    dataOut   = validOut ? head[sliceBase +: OUT_W] : '0;
    acceptedA = accA_q;
    level     = level_q;
  end

endmodule

// File: tb/tb_iab_serializer_fifo.sv
// Bench for iab_serializer_fifo: a default instance (64->8, DEPTH 4, burst) and an
// MSB-first, non-burst, DEPTH 3 instance, both checked against a frame-queue model.
module tb_iab_serializer_fifo;

  logic        clk;
  logic        rst_n;

  logic        readyAA, accAA, reqAA, gntAA, accIA, validAA, lastAA;
  logic [63:0] dataAA;
  logic [7:0]  doutAA;
  logic [2:0]  levelAA;

  logic        readyAB, accAB, reqAB, gntAB, accIB, validAB, lastAB;
  logic [31:0] dataAB;
  logic [7:0]  doutAB;
  logic [1:0]  levelAB;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] qA[$];
  logic [63:0] qB[$];
  int          idxA = 0;
  int          idxB = 0;

  iab_serializer_fifo #(.IN_W(64), .OUT_W(8), .DEPTH(4), .MSB_FIRST(1'b0), .BURST(1'b1)) dutA (
    .clk(clk), .rst_n(rst_n), .readyA(readyAA), .dataA(dataAA), .acceptedA(accAA),
    .reqIAB(reqAA), .gntIAB(gntAA), .acceptedI(accIA), .dataOut(doutAA),
    .validOut(validAA), .lastOut(lastAA), .level(levelAA)
  );

  iab_serializer_fifo #(.IN_W(32), .OUT_W(8), .DEPTH(3), .MSB_FIRST(1'b1), .BURST(1'b0)) dutB (
    .clk(clk), .rst_n(rst_n), .readyA(readyAB), .dataA(dataAB), .acceptedA(accAB),
    .reqIAB(reqAB), .gntIAB(gntAB), .acceptedI(accIB), .dataOut(doutAB),
    .validOut(validAB), .lastOut(lastAB), .level(levelAB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full four-phase offer; all driving and sampling happens on falling edges.
  task automatic pushFrame(input int sel, input logic [63:0] d);
    logic acc;
    if (sel == 0) begin readyAA = 1'b1; dataAA = d; end
    else begin readyAB = 1'b1; dataAB = d[31:0]; end
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = (sel == 0) ? accAA : accAB;
    end
    checkOutput("pushAccepted", acc, 1);
    if (acc) begin
      if (sel == 0) qA.push_back(d);
      else qB.push_back({32'h0, d[31:0]});
    end
    if (sel == 0) readyAA = 1'b0; else readyAB = 1'b0;
    for (int i = 0; i < 5 && acc; i++) begin
      @(negedge clk);
      acc = (sel == 0) ? accAA : accAB;
    end
    checkOutput("acceptedAFall", acc, 0);
  endtask

  // Waits for a valid slice, checks it against the head frame, then accepts it.
  task automatic consumeSlice(input int sel, output int waited);
    logic        v;
    logic [63:0] headFrame;
    logic [63:0] expSlice;
    int          n;
    int          k;
    waited = 0;
    v = (sel == 0) ? validAA : validAB;
    while (!v && waited < 20) begin
      @(negedge clk);
      waited++;
      v = (sel == 0) ? validAA : validAB;
    end
    checkOutput("validOut", v, 1);
    n = (sel == 0) ? 8 : 4;
    k = (sel == 0) ? idxA : idxB;
    if (sel == 0) headFrame = (qA.size() > 0) ? qA[0] : 64'h0;
    else          headFrame = (qB.size() > 0) ? qB[0] : 64'h0;
    if (sel == 0) expSlice = (headFrame >> (8 * k)) & 64'hFF;
    else          expSlice = (headFrame >> (8 * (n - 1 - k))) & 64'hFF;
    if (sel == 0) begin
      checkOutput("dataOutA", {56'h0, doutAA}, expSlice);
      checkOutput("lastOutA", lastAA, (k == n - 1));
      accIA = 1'b1; @(negedge clk); accIA = 1'b0;
    end else begin
      checkOutput("dataOutB", {56'h0, doutAB}, expSlice);
      checkOutput("lastOutB", lastAB, (k == n - 1));
      accIB = 1'b1; @(negedge clk); accIB = 1'b0;
    end
    k++;
    if (k == n) begin
      k = 0;
      if (sel == 0) void'(qA.pop_front()); else void'(qB.pop_front());
    end
    if (sel == 0) idxA = k; else idxB = k;
  endtask

  task automatic applyStimulus();
    int          w;
    logic [63:0] d5;
    logic        acc;

    // Reset state
    rst_n = 1'b0;
    readyAA = 0; dataAA = '0; gntAA = 0; accIA = 0;
    readyAB = 0; dataAB = '0; gntAB = 0; accIB = 0;
    repeat (3) @(negedge clk);
    checkOutput("rstAcceptedA", accAA, 0);
    checkOutput("rstReq", reqAA, 0);
    checkOutput("rstValid", validAA, 0);
    checkOutput("rstLast", lastAA, 0);
    checkOutput("rstData", {56'h0, doutAA}, 0);
    checkOutput("rstLevel", {61'h0, levelAA}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame, LS slice first
    pushFrame(0, 64'h8877665544332211);
    checkOutput("singleLevel", {61'h0, levelAA}, 1);
    @(negedge clk);
    checkOutput("singleReq", reqAA, 1);
    checkOutput("singleNoValid", validAA, 0);
    gntAA = 1'b1;
    for (int i = 0; i < 8; i++) consumeSlice(0, w);
    checkOutput("singleLevelEnd", {61'h0, levelAA}, 0);
    checkOutput("singleReqDrop", reqAA, 0);
    checkOutput("singleValidDrop", validAA, 0);

    // Fill to DEPTH with no grant; fifth offer must stall
    gntAA = 1'b0;
    for (int f = 0; f < 4; f++) begin
      pushFrame(0, {$urandom, $urandom});
      checkOutput("fillLevel", {61'h0, levelAA}, 64'(qA.size()));
    end
    d5 = {$urandom, $urandom};
    readyAA = 1'b1; dataAA = d5;
    repeat (6) @(negedge clk);
    checkOutput("fullStall", accAA, 0);
    checkOutput("fullLevel", {61'h0, levelAA}, 4);
    gntAA = 1'b1;
    for (int i = 0; i < 8; i++) consumeSlice(0, w);
    checkOutput("popNoSameCyclePush", accAA, 0);
    checkOutput("popLevel", {61'h0, levelAA}, 3);
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      @(negedge clk);
      acc = accAA;
    end
    checkOutput("fifthAccepted", acc, 1);
    if (acc) qA.push_back(d5);
    readyAA = 1'b0;
    @(negedge clk);
    checkOutput("fifthAccFall", accAA, 0);

    // Burst drain: one slice per cycle with reqIAB held throughout
    for (int i = 0; i < 32; i++) begin
      checkOutput("burstReq", reqAA, 1);
      consumeSlice(0, w);
      checkOutput("burstNoGap", 64'(w), 0);
    end
    checkOutput("burstLevelEnd", {61'h0, levelAA}, 0);
    checkOutput("burstReqDrop", reqAA, 0);

    // Grant loss after the third slice
    gntAA = 1'b0;
    pushFrame(0, 64'h8877665544332211);
    gntAA = 1'b1;
    for (int i = 0; i < 3; i++) consumeSlice(0, w);
    gntAA = 1'b0;
    @(negedge clk);
    checkOutput("lossValid", validAA, 0);
    checkOutput("lossReq", reqAA, 1);
    repeat (2) @(negedge clk);
    checkOutput("lossReqHeld", reqAA, 1);
    gntAA = 1'b1;
    consumeSlice(0, w);
    checkOutput("regrantLatency", 64'(w), 1);
    for (int i = 0; i < 4; i++) consumeSlice(0, w);
    checkOutput("lossLevelEnd", {61'h0, levelAA}, 0);

    // Reset during slice 5 with two frames buffered
    pushFrame(0, {$urandom, $urandom});
    pushFrame(0, {$urandom, $urandom});
    for (int i = 0; i < 5; i++) consumeSlice(0, w);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midRstValid", validAA, 0);
    checkOutput("midRstReq", reqAA, 0);
    checkOutput("midRstLast", lastAA, 0);
    checkOutput("midRstData", {56'h0, doutAA}, 0);
    checkOutput("midRstLevel", {61'h0, levelAA}, 0);
    checkOutput("midRstAcc", accAA, 0);
    rst_n = 1'b1;
    qA.delete();
    idxA = 0;
    @(negedge clk);
    pushFrame(0, {$urandom, $urandom});
    for (int i = 0; i < 8; i++) consumeSlice(0, w);
    checkOutput("postRstLevel", {61'h0, levelAA}, 0);

    // MSB-first, non-burst instance
    pushFrame(1, 64'hA1B2C3D4);
    pushFrame(1, {32'h0, $urandom});
    checkOutput("bLevel2", {62'h0, levelAB}, 2);
    gntAB = 1'b1;
    for (int i = 0; i < 4; i++) consumeSlice(1, w);
    checkOutput("bGapValid", validAB, 0);
    checkOutput("bGapReq", reqAB, 1);
    consumeSlice(1, w);
    checkOutput("bReqLatency", 64'(w), 1);
    for (int i = 0; i < 3; i++) consumeSlice(1, w);
    checkOutput("bLevelEnd", {62'h0, levelAB}, 0);
    checkOutput("bReqDrop", reqAB, 0);

    // Fill the DEPTH-3 FIFO so its pointers wrap, then drain in order
    gntAB = 1'b0;
    for (int f = 0; f < 3; f++) pushFrame(1, {32'h0, $urandom});
    checkOutput("bFullLevel", {62'h0, levelAB}, 3);
    gntAB = 1'b1;
    for (int i = 0; i < 12; i++) consumeSlice(1, w);
    checkOutput("bDrainLevel", {62'h0, levelAB}, 0);
  endtask

  initial begin
    applyStimulus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
